// File: rtl/half_packer_pkg.sv
// half_packer_pkg: state encodings and timer sizing shared by the packer files
package half_packer_pkg;
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;
    function automatic int timer_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return w < 1 ? 1 : w;
    endfunction
endpackage

// File: rtl/half_packer_if.sv
// half_packer_if: narrow beat stream in, packed FIFO write port out
interface half_packer_if #(parameter int DATA_WIDTH = 8);
    logic [DATA_WIDTH-1:0]   s_data;
    logic                    s_valid;
    logic                    s_ready;
    logic                    flush;
    logic                    fifo_full;
    logic                    wr;
    logic [2*DATA_WIDTH-1:0] w_data;
    logic                    w_pad;
    logic                    busy;
    modport master (output s_data, s_valid, flush, fifo_full, input s_ready, wr, w_data, w_pad, busy);
    modport slave (input s_data, s_valid, flush, fifo_full, output s_ready, wr, w_data, w_pad, busy);
endinterface

// File: rtl/half_packer_idle_timer.sv
// idle_timer: saturating idle counter that flags expiry at TIMEOUT-1
module idle_timer
    import half_packer_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int W = timer_width(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
    localparam logic [W-1:0] TOP = W'(TIMEOUT);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (clr || TIMEOUT == 0)
            cnt <= '0;
        else if (en && cnt != TOP)
            cnt <= cnt + 1'b1;
    end
    assign expire = (TIMEOUT != 0) && (cnt == LAST);
endmodule

// File: rtl/half_packer.sv
// half_packer: packs beat pairs into double-width FIFO words, padding a lone beat on flush or idle timeout
module half_packer
    import half_packer_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    TIMEOUT    = 255,
    parameter logic [DATA_WIDTH-1:0] PAD        = '0
) (
    input logic         clk,
    input logic         reset_n,
    half_packer_if.slave bus
);
    state_t                  state, state_n;
    logic [DATA_WIDTH-1:0]   lo, lo_n;
    logic [2*DATA_WIDTH-1:0] w_data, w_data_n;
    logic                    w_pad, w_pad_n;
    logic                    hs, clr, expire;
    idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk(clk),
        .reset_n(reset_n),
        .clr(clr),
        .en(state == ST_HALF),
        .expire(expire)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_EMPTY;
            lo     <= '0;
            w_data <= '0;
            w_pad  <= 1'b0;
        end else begin
            state  <= state_n;
            lo     <= lo_n;
            w_data <= w_data_n;
            w_pad  <= w_pad_n;
        end
    end
    // a handshake in HALF outranks flush and timeout
    always_comb begin
        state_n  = state;
        lo_n     = lo;
        w_data_n = w_data;
        w_pad_n  = w_pad;
        clr      = 1'b0;
        unique case (state)
            ST_EMPTY: if (hs) begin
                lo_n    = bus.s_data;
                clr     = 1'b1;
                state_n = ST_HALF;
            end
            ST_HALF: if (hs) begin
                w_data_n = {bus.s_data, lo};
                w_pad_n  = 1'b0;
                state_n  = ST_WAIT;
            end else if (bus.flush || expire) begin
                w_data_n = {PAD, lo};
                w_pad_n  = 1'b1;
                state_n  = ST_WAIT;
            end
            ST_WAIT: if (bus.wr) begin
                lo_n    = hs ? bus.s_data : lo;
                clr     = hs;
                state_n = hs ? ST_HALF : ST_EMPTY;
            end
            default: state_n = ST_EMPTY;
        endcase
    end
    assign hs          = bus.s_valid && bus.s_ready;
    assign bus.s_ready = (state != ST_WAIT) || !bus.fifo_full;
    assign bus.wr      = (state == ST_WAIT) && !bus.fifo_full;
    assign bus.w_data  = w_data;
    assign bus.w_pad   = w_pad;
    assign bus.busy    = state != ST_EMPTY;
endmodule

// File: tb/tb_half_packer.sv
// tb_half_packer: directed checks of pairing, backpressure, timeout, flush and reset
module tb_half_packer;
    localparam int DW = 8;
    logic clk = 1'b0;
    logic reset_n;
    int   vectors = 0;
    int   miscompares = 0;
    half_packer_if #(.DATA_WIDTH(DW)) bus ();
    half_packer #(.DATA_WIDTH(DW), .TIMEOUT(4), .PAD(8'h00)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    initial begin
        reset_n       = 1'b0;
        bus.s_valid   = 1'b1;
        bus.s_data    = 8'h99;
        bus.flush     = 1'b0;
        bus.fifo_full = 1'b0;
        tick();
        tick();
        check("rst_wr", 16'(bus.wr), 16'h0);
        check("rst_w_data", bus.w_data, 16'h0000);
        check("rst_w_pad", 16'(bus.w_pad), 16'h0);
        check("rst_busy", 16'(bus.busy), 16'h0);
        check("rst_s_ready", 16'(bus.s_ready), 16'h1);
        bus.s_valid = 1'b0;
        reset_n = 1'b1;
        tick();
        check("post_rst_busy", 16'(bus.busy), 16'h0);
        // basic pair
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h11;
        tick();
        check("pair_half_busy", 16'(bus.busy), 16'h1);
        check("pair_half_wr", 16'(bus.wr), 16'h0);
        bus.s_data = 8'h22;
        tick();
        bus.s_valid = 1'b0;
        #1;
        check("pair_wr", 16'(bus.wr), 16'h1);
        check("pair_w_data", bus.w_data, 16'h2211);
        check("pair_w_pad", 16'(bus.w_pad), 16'h0);
        tick();
        check("pair_wr_once", 16'(bus.wr), 16'h0);
        check("pair_idle", 16'(bus.busy), 16'h0);
        // sustained stream 01..08
        for (int i = 1; i <= 8; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'(i);
            #1;
            check("stream_s_ready", 16'(bus.s_ready), 16'h1);
            check("stream_wr", 16'(bus.wr), 16'((i > 2) && (i % 2 == 1)));
            if (bus.wr)
                check("stream_w_data", bus.w_data, {8'(i - 1), 8'(i - 2)});
            tick();
        end
        bus.s_valid = 1'b0;
        #1;
        check("stream_last_wr", 16'(bus.wr), 16'h1);
        check("stream_last_w_data", bus.w_data, 16'h0807);
        tick();
        check("stream_idle", 16'(bus.busy), 16'h0);
        // backpressure with a beat waiting behind the full FIFO
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hAA;
        tick();
        bus.s_data = 8'hBB;
        tick();
        bus.s_data    = 8'hCC;
        bus.fifo_full = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("bp_wr", 16'(bus.wr), 16'h0);
            check("bp_s_ready", 16'(bus.s_ready), 16'h0);
            check("bp_w_data", bus.w_data, 16'hBBAA);
            tick();
        end
        bus.fifo_full = 1'b0;
        #1;
        check("bp_release_wr", 16'(bus.wr), 16'h1);
        check("bp_release_w_data", bus.w_data, 16'hBBAA);
        tick();
        check("bp_no_dup_wr", 16'(bus.wr), 16'h0);
        check("bp_cc_held", 16'(bus.busy), 16'h1);
        bus.s_data = 8'hDD;
        tick();
        bus.s_valid = 1'b0;
        #1;
        check("bp_next_wr", 16'(bus.wr), 16'h1);
        check("bp_next_w_data", bus.w_data, 16'hDDCC);
        tick();
        check("bp_idle", 16'(bus.busy), 16'h0);
        // idle timeout pads the lone beat
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hAB;
        tick();
        bus.s_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("to_still_half_wr", 16'(bus.wr), 16'h0);
            check("to_still_half_busy", 16'(bus.busy), 16'h1);
        end
        tick();
        check("to_wr", 16'(bus.wr), 16'h1);
        check("to_w_data", bus.w_data, 16'h00AB);
        check("to_w_pad", 16'(bus.w_pad), 16'h1);
        tick();
        check("to_wr_once", 16'(bus.wr), 16'h0);
        check("to_idle", 16'(bus.busy), 16'h0);
        // flush with a simultaneous handshake completes a normal word
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h33;
        tick();
        bus.s_data = 8'h44;
        bus.flush  = 1'b1;
        tick();
        bus.s_valid = 1'b0;
        #1;
        check("fp_wr", 16'(bus.wr), 16'h1);
        check("fp_w_data", bus.w_data, 16'h4433);
        check("fp_w_pad", 16'(bus.w_pad), 16'h0);
        tick();
        check("fp_no_pad_word", 16'(bus.busy), 16'h0);
        tick();
        check("fp_empty_flush_noop", 16'(bus.busy), 16'h0);
        bus.flush = 1'b0;
        // explicit flush of a lone beat
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h5A;
        tick();
        bus.s_valid = 1'b0;
        bus.flush   = 1'b1;
        tick();
        bus.flush = 1'b0;
        #1;
        check("fl_wr", 16'(bus.wr), 16'h1);
        check("fl_w_data", bus.w_data, 16'h005A);
        check("fl_w_pad", 16'(bus.w_pad), 16'h1);
        tick();
        // reset while holding a half-word
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h55;
        tick();
        bus.s_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("mr_busy", 16'(bus.busy), 16'h0);
        check("mr_wr", 16'(bus.wr), 16'h0);
        check("mr_w_data", bus.w_data, 16'h0000);
        check("mr_w_pad", 16'(bus.w_pad), 16'h0);
        tick();
        reset_n = 1'b1;
        tick();
        check("mr_after_wr", 16'(bus.wr), 16'h0);
        check("mr_after_busy", 16'(bus.busy), 16'h0);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h66;
        tick();
        check("mr_half_wr", 16'(bus.wr), 16'h0);
        bus.s_data = 8'h77;
        tick();
        bus.s_valid = 1'b0;
        #1;
        check("mr_wr_after", 16'(bus.wr), 16'h1);
        check("mr_w_data_after", bus.w_data, 16'h7766);
        check("mr_w_pad_after", 16'(bus.w_pad), 16'h0);
        tick();
        check("mr_idle", 16'(bus.busy), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/half_packer.md
# half_packer

Upstream feeder for the width-converting FIFO. Accepts a stream of narrow `DATA_WIDTH` beats over valid/ready, packs consecutive pairs into one `2*DATA_WIDTH` word, and issues single-cycle `wr` strobes to the FIFO write port, honouring its `full` flag. A lone trailing beat is padded and pushed when an explicit `flush` arrives or when an idle timeout expires, so no data is stranded in the packer.

## Interface
- `DATA_WIDTH`, 8: narrow beat width. FIFO word width is `2*DATA_WIDTH`.
- `TIMEOUT`, 255: number of idle cycles spent in HALF before auto-padding. 0 disables the timer.
- `PAD`, 0: `DATA_WIDTH`-bit value placed in the upper half of a padded word.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `s_data` in `DATA_WIDTH`: narrow input beat.
- `s_valid` in 1: `s_data` valid.
- `s_ready` out 1: packer can accept a beat.
- `flush` in 1: push any held half-word, padded.
- `fifo_full` in 1: FIFO full flag.
- `wr` out 1: FIFO write strobe.
- `w_data` out `2*DATA_WIDTH`: FIFO write word.
- `w_pad` out 1: current `w_data` upper half is `PAD`, not data.
- `busy` out 1: state is not EMPTY.

## Operation
- Byte order:
  - The first accepted beat goes to `w_data[DATA_WIDTH-1:0]`.
  - The second accepted beat goes to `w_data[2*DATA_WIDTH-1:DATA_WIDTH]`.
  - This matches the FIFO read order, which is low half first.
- A handshake occurs on any rising edge where `s_valid && s_ready`.
- States:
  - **EMPTY**
    - `s_ready=1`.
    - Handshake: `lo<=s_data`, timer cleared, go to HALF.
    - `flush` is a no-op.
  - **HALF**
    - `s_ready=1`.
    - Handshake: `w_data<={s_data,lo}`, `w_pad<=0`, go to WAIT. A handshake takes priority over `flush` and over the timeout.
    - Otherwise, if `flush` is high, or `TIMEOUT!=0 && timer==TIMEOUT-1`: `w_data<={PAD,lo}`, `w_pad<=1`, go to WAIT.
    - Otherwise `timer++`.
  - **WAIT**
    - `wr = !fifo_full` (combinational).
    - `s_ready = !fifo_full`.
    - On `wr` with a handshake: `lo<=s_data`, timer cleared, go to HALF.
    - On `wr` without a handshake: go to EMPTY.
    - While `fifo_full` is high: hold state; `w_data` and `w_pad` stay stable.
    - `flush` has no effect in WAIT.
- `wr` is 0 in EMPTY and HALF.
- `busy = (state!=EMPTY)`.
- Timer width is `$clog2(TIMEOUT+1)`, minimum 1. It saturates and never wraps.

## Timing
- Reset values:
  - State EMPTY.
  - `wr=0`, `w_data=0`, `w_pad=0`, `busy=0`, `s_ready=1`, timer 0, `lo=0`.
- Handshakes during `reset_n` low are dropped.
- Reset mid-operation discards any held half-word or pending word with no `wr`.
- Latency:
  - Second beat accepted at edge t gives `wr` high in cycle t+1 if `fifo_full=0`.
- Throughput:
  - One beat per cycle sustained, one word every 2 cycles, with `s_ready` never deasserted while `fifo_full=0`.
- Timeout:
  - Beat accepted at edge t, then idle: transition to WAIT occurs at edge t+`TIMEOUT`.
  - `wr` is high in the following cycle.
- Backpressure:
  - `wr` and `s_ready` follow `fifo_full` combinationally in WAIT.
  - The FIFO samples `wr` on the same edge that its `full` is evaluated, so no write is issued while `fifo_full=1`.
- Simultaneous events:
  - `flush` together with a handshake in HALF completes a normal unpadded word.
  - `flush` together with a WAIT-to-HALF handshake applies on the next cycle.

## Structure
- Shared package/include `half_packer_pkg`:
  - State encodings `ST_EMPTY=2'd0`, `ST_HALF=2'd1`, `ST_WAIT=2'd2`.
  - Timer-width function.
- Sub-module `idle_timer`:
  - Clear/enable inputs, `expire` output at count `TIMEOUT-1`.
  - Held at 0 when `TIMEOUT==0`.
- Everything else is in one always-block pair (registers plus next-state logic).

## Test plan
- **Basic pair:** reset, send 0x11 then 0x22 back-to-back, `fifo_full=0`.
  - `wr` high exactly one cycle, the cycle after 0x22 is accepted.
  - `w_data=0x2211`, `w_pad=0`.
- **Sustained stream:** beats 0x01..0x08, one per cycle.
  - Four `wr` pulses with words 0x0201, 0x0403, 0x0605, 0x0807.
  - `s_ready` constantly 1.
- **Backpressure:** `fifo_full=1` for 5 cycles while in WAIT with 0xBBAA.
  - `wr=0`, `s_ready=0`, `w_data` stable for all 5 cycles.
  - `wr=1` in the cycle `fifo_full` falls.
  - No duplicate write.
- **Timeout:** `TIMEOUT=4`, `PAD=0`, single beat 0xAB, then idle.
  - WAIT entered 4 edges after acceptance.
  - `w_data=0x00AB`, `w_pad=1`, one `wr`.
- **Flush priority:** in HALF holding 0x33, assert `flush` and `s_valid` with 0x44 on the same cycle.
  - `w_data=0x4433`, `w_pad=0`, no padded word follows.
- **Reset mid-operation:** in HALF holding 0x55, pulse `reset_n` low.
  - `wr` never asserts for 0x55.
  - After release, 0x66, 0x77 gives `w_data=0x7766`.
